// File: rtl/cmos_dvp_source.sv
// OV5640-style DVP byte-stream source: vsync/href/data timing with RGB565 pixels,
// either a bouncing square target on a flat background or eight vertical colour bars.
module cmos_dvp_source #(
  parameter int          H_PIXEL     = 640,
  parameter int          V_PIXEL     = 480,
  parameter int          H_BLANK     = 144,
  parameter int          VSYNC_LINES = 4,
  parameter int          V_BACK      = 20,
  parameter int          V_FRONT     = 10,
  parameter int          OBJ_SIZE    = 32,
  parameter int          OBJ_STEP    = 4,
  parameter logic [15:0] BG_COLOR    = 16'h0000,
  parameter logic [15:0] OBJ_COLOR   = 16'hFFFF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       pattern_sel,
  output logic       cam_vsync,
  output logic       cam_href,
  output logic [7:0] cam_data,
  output logic       frame_done,
  output logic [9:0] obj_x,
  output logic [9:0] obj_y
);

  localparam int          LINE       = 2*H_PIXEL + H_BLANK;
  localparam logic [11:0] H_LAST     = 12'(LINE - 1);
  localparam logic [11:0] H_ACTIVE   = 12'(2*H_PIXEL);
  localparam logic [10:0] VS_LAST    = 11'(VSYNC_LINES - 1);
  localparam logic [10:0] VB_LAST    = 11'(V_BACK - 1);
  localparam logic [10:0] VA_LAST    = 11'(V_PIXEL - 1);
  localparam logic [10:0] VF_LAST    = 11'(V_FRONT - 1);
  localparam logic [10:0] SIZE_W     = 11'(OBJ_SIZE);
  localparam logic [10:0] STEP_W     = 11'(OBJ_STEP);
  localparam logic [10:0] X_LIMIT    = 11'(H_PIXEL - OBJ_SIZE);
  localparam logic [10:0] Y_LIMIT    = 11'(V_PIXEL - OBJ_SIZE);
  localparam logic [13:0] H_PIXEL_W  = 14'(H_PIXEL);

  typedef enum logic [2:0] {IDLE, VSYNC, VBACK, ACTIVE, VFRONT} state_t;

  state_t      state, state_n;
  logic [11:0] hcnt, hcnt_n;
  logic [10:0] vcnt, vcnt_n;
  logic        frame_end, frame_start;
  logic        pattern_q, x_neg, y_neg;
  logic [9:0]  px, py;
  logic [13:0] bar_num;
  logic [2:0]  bar_idx;
  logic [15:0] colour;
  logic        vsync_n, href_n, done_n;
  logic [7:0]  data_n;

  // Returns {new_direction_is_negative, new_position}.
  function automatic logic [10:0] bounce(input logic [9:0] pos, input logic neg,
                                         input logic [10:0] limit);
    logic [10:0] p, n;
    p = {1'b0, pos};
    n = p + STEP_W;
    if (!neg) begin
      if (n > limit) bounce = {1'b1, 10'(p - STEP_W)};
      else           bounce = {1'b0, 10'(n)};
    end else begin
      if (p < STEP_W) bounce = {1'b0, 10'(n)};
      else            bounce = {1'b1, 10'(p - STEP_W)};
    end
  endfunction

  always_comb begin
    state_n   = state;
    hcnt_n    = hcnt;
    vcnt_n    = vcnt;
    frame_end = 1'b0;
    if (state == IDLE) begin
      if (en) begin
        state_n = VSYNC;
        hcnt_n  = '0;
        vcnt_n  = '0;
      end
    end else if (hcnt != H_LAST) begin
      hcnt_n = hcnt + 12'd1;
    end else begin
      hcnt_n = '0;
      vcnt_n = vcnt + 11'd1;
      case (state)
        VSYNC:  if (vcnt == VS_LAST) begin state_n = VBACK;  vcnt_n = '0; end
        VBACK:  if (vcnt == VB_LAST) begin state_n = ACTIVE; vcnt_n = '0; end
        ACTIVE: if (vcnt == VA_LAST) begin state_n = VFRONT; vcnt_n = '0; end
        VFRONT: if (vcnt == VF_LAST) begin
          vcnt_n    = '0;
          frame_end = 1'b1;
          state_n   = en ? VSYNC : IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
    frame_start = en && ((state == IDLE) || frame_end);
  end

  // Outputs are decoded from the next position so the registered outputs line up with it.
  always_comb begin
    px      = hcnt_n[10:1];
    py      = vcnt_n[9:0];
    bar_num = {1'b0, px, 3'b000};
    bar_idx = 3'(bar_num / H_PIXEL_W);
    colour  = BG_COLOR;
    if (pattern_q) begin
      case (bar_idx)
        3'd0: colour = 16'hFFFF;
        3'd1: colour = 16'hFFE0;
        3'd2: colour = 16'h07FF;
        3'd3: colour = 16'h07E0;
        3'd4: colour = 16'hF81F;
        3'd5: colour = 16'hF800;
        3'd6: colour = 16'h001F;
        3'd7: colour = 16'h0000;
        default: colour = 16'h0000;
      endcase
    end else if (({1'b0, px} >= {1'b0, obj_x}) && ({1'b0, px} < {1'b0, obj_x} + SIZE_W) &&
                 ({1'b0, py} >= {1'b0, obj_y}) && ({1'b0, py} < {1'b0, obj_y} + SIZE_W)) begin
      colour = OBJ_COLOR;
    end
    vsync_n = (state_n == VSYNC);
    href_n  = (state_n == ACTIVE) && (hcnt_n < H_ACTIVE);
    done_n  = (state_n == VFRONT) && (hcnt_n == H_LAST) && (vcnt_n == VF_LAST);
    data_n  = href_n ? (hcnt_n[0] ? colour[7:0] : colour[15:8]) : 8'h00;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      hcnt       <= '0;
      vcnt       <= '0;
      pattern_q  <= 1'b0;
      x_neg      <= 1'b0;
      y_neg      <= 1'b0;
      obj_x      <= '0;
      obj_y      <= '0;
      cam_vsync  <= 1'b0;
      cam_href   <= 1'b0;
      cam_data   <= 8'h00;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      hcnt       <= hcnt_n;
      vcnt       <= vcnt_n;
      cam_vsync  <= vsync_n;
      cam_href   <= href_n;
      cam_data   <= data_n;
      frame_done <= done_n;
      if (frame_start) pattern_q <= pattern_sel;
      // Target moves between frames only, so a frame never shows a torn square.
      if (frame_end) begin
        {x_neg, obj_x} <= bounce(obj_x, x_neg, X_LIMIT);
        {y_neg, obj_y} <= bounce(obj_y, y_neg, Y_LIMIT);
      end
    end
  end

endmodule

// File: tb/tb_cmos_dvp_source.sv
// Bench for cmos_dvp_source: frame-position reference model checked every cycle,
// directed scenarios for timing, target motion, colour bars and reset, then random traffic.
module tb_cmos_dvp_source;
  localparam int HP = 8, VP = 4, HB = 4, VS = 1, VB = 1, VF = 1, OS = 2, ST = 2;
  localparam int L = 2*HP + HB;
  localparam int FRAME = (VS + VB + VP + VF) * L;
  localparam logic [15:0] BARS [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                       16'hF81F, 16'hF800, 16'h001F, 16'h0000};
  localparam logic [7:0] ROW_BYTES [16] = '{8'hFF, 8'hFF, 8'hFF, 8'hE0, 8'h07, 8'hFF, 8'h07, 8'hE0,
                                           8'hF8, 8'h1F, 8'hF8, 8'h00, 8'h00, 8'h1F, 8'h00, 8'h00};
  localparam int EXP_X [5] = '{0, 2, 4, 6, 4};
  localparam int EXP_Y [5] = '{0, 2, 0, 2, 0};
  localparam logic [7:0] ROW0_HEAD [6] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00};

  logic       clk = 1'b0;
  logic       rst, en, pattern_sel;
  logic       cam_vsync, cam_href, frame_done;
  logic [7:0] cam_data;
  logic [9:0] obj_x, obj_y;

  int checks = 0;
  int fails  = 0;

  bit busy = 1'b0;
  int k = 0, pat = 0, mx = 0, my = 0, mdx = 1, mdy = 1;
  int vs_cnt = 0, done_cnt = 0;
  logic [7:0] bytes_q [$];

  always #5 clk = ~clk;

  cmos_dvp_source #(
    .H_PIXEL(HP), .V_PIXEL(VP), .H_BLANK(HB), .VSYNC_LINES(VS), .V_BACK(VB),
    .V_FRONT(VF), .OBJ_SIZE(OS), .OBJ_STEP(ST), .BG_COLOR(16'h0000), .OBJ_COLOR(16'hFFFF)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .pattern_sel(pattern_sel),
    .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_data(cam_data),
    .frame_done(frame_done), .obj_x(obj_x), .obj_y(obj_y)
  );

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      fails++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", tag, $time, actual, expected);
    end
  endtask

  task automatic bounceAxis(inout int p, inout int d, input int lim);
    if (d > 0) begin
      if (p + ST > lim) begin d = -1; p = p - ST; end
      else p = p + ST;
    end else begin
      if (p < ST) begin d = 1; p = p + ST; end
      else p = p - ST;
    end
  endtask

  // Reference: a frame is just a position k in 0..FRAME-1 while busy.
  task automatic modelStep();
    if (rst) begin
      busy = 1'b0; k = 0; mx = 0; my = 0; mdx = 1; mdy = 1;
    end else if (!busy) begin
      if (en) begin busy = 1'b1; k = 0; pat = int'(pattern_sel); end
    end else if (k == FRAME - 1) begin
      bounceAxis(mx, mdx, HP - OS);
      bounceAxis(my, mdy, VP - OS);
      if (en) begin k = 0; pat = int'(pattern_sel); end
      else busy = 1'b0;
    end else begin
      k++;
    end
  endtask

  task automatic compareAll();
    int line, h, px, py;
    logic [15:0] c;
    bit act;
    int exp_data;
    line = k / L;
    h    = k % L;
    act  = busy && line >= VS + VB && line < VS + VB + VP && h < 2*HP;
    exp_data = 0;
    if (act) begin
      px = h / 2;
      py = line - VS - VB;
      if (pat != 0) c = BARS[px*8/HP];
      else c = (px >= mx && px < mx + OS && py >= my && py < my + OS) ? 16'hFFFF : 16'h0000;
      exp_data = (h % 2 == 1) ? int'(c[7:0]) : int'(c[15:8]);
    end
    checkOutput("vsync", int'(cam_vsync), int'(busy && line < VS));
    checkOutput("href", int'(cam_href), int'(act));
    checkOutput("data", int'(cam_data), exp_data);
    checkOutput("frame_done", int'(frame_done), int'(busy && k == FRAME - 1));
    checkOutput("obj_x", int'(obj_x), mx);
    checkOutput("obj_y", int'(obj_y), my);
  endtask

  task automatic tick();
    @(posedge clk);
    modelStep();
    @(negedge clk);
    compareAll();
    if (cam_vsync) vs_cnt++;
    if (frame_done) done_cnt++;
    if (cam_href) bytes_q.push_back(cam_data);
  endtask

  task automatic applyStimulus(input bit r, input bit e, input bit p, input int n);
    rst = r; en = e; pattern_sel = p;
    repeat (n) tick();
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; pattern_sel = 1'b0;
    applyStimulus(1, 0, 0, 3);

    // Single frame from a one-cycle en pulse.
    vs_cnt = 0; done_cnt = 0; bytes_q.delete();
    applyStimulus(0, 1, 0, 1);
    applyStimulus(0, 0, 0, FRAME + 19);
    checkOutput("single_vsync_len", vs_cnt, VS*L);
    checkOutput("single_done_cnt", done_cnt, 1);
    checkOutput("single_href_bytes", bytes_q.size(), 2*HP*VP);

    // Five back-to-back frames, target motion.
    applyStimulus(1, 0, 0, 2);
    for (int f = 0; f < 5; f++) begin
      bytes_q.delete();
      applyStimulus(0, 1, 0, 1);
      checkOutput("frame_obj_x", int'(obj_x), EXP_X[f]);
      checkOutput("frame_obj_y", int'(obj_y), EXP_Y[f]);
      applyStimulus(0, (f != 4), 0, FRAME - 1);
      checkOutput("frame_words", bytes_q.size() / 2, HP*VP);
      if (f == 0) begin
        for (int i = 0; i < 6; i++) checkOutput("row0_byte", int'(bytes_q[i]), int'(ROW0_HEAD[i]));
        for (int i = 2*2*HP; i < 4*2*HP; i++) checkOutput("rows23_byte", int'(bytes_q[i]), 0);
      end
    end

    // Colour bars; flipping pattern_sel mid-frame must not matter.
    bytes_q.delete();
    applyStimulus(0, 1, 1, 1);
    applyStimulus(0, 0, 1, 50);
    applyStimulus(0, 0, 0, FRAME - 51);
    checkOutput("bar_bytes", bytes_q.size(), 2*HP*VP);
    for (int i = 0; i < 2*HP*VP; i++) checkOutput("bar_byte", int'(bytes_q[i]), int'(ROW_BYTES[i % 16]));

    // en dropped mid-ACTIVE: frame completes, nothing follows.
    vs_cnt = 0; done_cnt = 0; bytes_q.delete();
    applyStimulus(0, 1, 0, 60);
    applyStimulus(0, 0, 0, FRAME);
    checkOutput("drop_vsync_len", vs_cnt, VS*L);
    checkOutput("drop_done_cnt", done_cnt, 1);
    checkOutput("drop_href_bytes", bytes_q.size(), 2*HP*VP);

    // Reset during ACTIVE line 2, then restart.
    applyStimulus(0, 1, 0, 2*FRAME + 85);
    applyStimulus(1, 1, 0, 1);
    checkOutput("rst_href", int'(cam_href), 0);
    checkOutput("rst_data", int'(cam_data), 0);
    checkOutput("rst_obj_x", int'(obj_x), 0);
    checkOutput("rst_obj_y", int'(obj_y), 0);
    applyStimulus(0, 1, 0, 1);
    checkOutput("restart_vsync", int'(cam_vsync), 1);
    applyStimulus(0, 1, 0, FRAME);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(($urandom_range(0, 399) == 0), ($urandom_range(0, 99) < 70),
                    1'($urandom_range(0, 1)), 1);
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/cmos_dvp_source.md
Name: cmos_dvp_source

Overview:
- Synthesizable OV5640-style DVP transmitter: the sensor-side end of the camera capture path.
- Generates registered vsync/href/8-bit data byte stream, RGB565 high byte first, two bytes per pixel, with a bouncing square target.
- Drives the moving-object-detection pipeline and SDRAM write path in simulation and on-board self-test without a physical camera.
- Consumer samples all outputs on the same clk (pixel clock).

Parameters:
- H_PIXEL, 640: active pixels per line.
- V_PIXEL, 480: active lines per frame.
- H_BLANK, 144: href-low clocks at the end of every line.
- VSYNC_LINES, 4: lines with vsync high.
- V_BACK, 20: blank lines between vsync and first active line.
- V_FRONT, 10: blank lines after the last active line.
- OBJ_SIZE, 32: target square side, pixels.
- OBJ_STEP, 4: target motion per frame in x and y, pixels.
- BG_COLOR, 16'h0000: background RGB565.
- OBJ_COLOR, 16'hFFFF: target RGB565.

Ports:
- clk, in, 1: pixel/byte clock.
- rst, in, 1: synchronous, active-high reset.
- en, in, 1: run request; sampled only at frame boundaries.
- pattern_sel, in, 1: 0 = background plus target; 1 = 8 vertical colour bars, no target. Latched at frame start.
- cam_vsync, out, 1: frame sync, active high.
- cam_href, out, 1: line valid, high during active bytes.
- cam_data, out, 8: pixel byte.
- frame_done, out, 1: one-cycle pulse on the last clock of each frame's V_FRONT period.
- obj_x, out, 10: left column of the target in the current frame.
- obj_y, out, 10: top row of the target in the current frame.

Behaviour:
- Reset values: all outputs 0, state IDLE, obj_x = obj_y = 0, direction +x/+y, all counters 0. Reset mid-frame aborts immediately; the next clock is IDLE with outputs 0.
- All outputs are registered. Line length L = 2*H_PIXEL + H_BLANK clocks; the byte counter hcnt runs 0..L-1.
- State machine, with vcnt counting lines inside each state:
  - IDLE: if en=1, go to VSYNC. cam_vsync goes high on the next clock (1-cycle latency). Latch pattern_sel.
  - VSYNC: cam_vsync=1 for VSYNC_LINES*L clocks, then go to VBACK.
  - VBACK: V_BACK lines, all outputs low, then go to ACTIVE.
  - ACTIVE: V_PIXEL lines. cam_href=1 for hcnt 0..2*H_PIXEL-1, then low for H_BLANK. Pixel px = hcnt>>1, row py = vcnt. hcnt even emits colour[15:8]; hcnt odd emits colour[7:0].
  - VFRONT: V_FRONT lines, outputs low. frame_done pulses on the final clock. Then:
    - If en=1, go directly to VSYNC (back-to-back frames, no IDLE gap).
    - Otherwise go to IDLE.
- en is ignored mid-frame; deasserting it completes the current frame first.
- cam_data is 0 whenever cam_href=0.
- Colour, pattern 0: OBJ_COLOR when obj_x <= px < obj_x+OBJ_SIZE and obj_y <= py < obj_y+OBJ_SIZE; otherwise BG_COLOR.
- Colour, pattern 1: bar index = px*8/H_PIXEL, 0..7. Bars in order: FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000.
- Target update happens on the frame_done clock and becomes visible from the next frame; obj_x/obj_y hold stable during a frame. X rule, with y identical using V_PIXEL:
  - Moving +: n = x + STEP. If n > H_PIXEL - OBJ_SIZE, reverse to - and set x = x - STEP; else x = n.
  - Moving -: if x < STEP, reverse to + and set x = x + STEP; else x = x - STEP.
  - Widths: 11-bit internal arithmetic, no wrap-around.
  - Both axes update independently in the same cycle.

Test Plan (small params: H_PIXEL=8, V_PIXEL=4, H_BLANK=4, VSYNC_LINES=1, V_BACK=1, V_FRONT=1, OBJ_SIZE=2, OBJ_STEP=2; L=20, frame=140 clocks):
1. Reset, then en=1 held for one cycle, then en=0 → cam_vsync high exactly 20 clocks starting 1 clock after en; 4 href pulses each 16 clocks high with 4 clocks low between; frame_done once at clock 140; then IDLE with all outputs 0.
2. en held high, pattern_sel=0, 5 frames → (obj_x,obj_y) per frame: (0,0), (2,2), (4,0), (6,2), (4,0). Frame 0, row 0 bytes: FF FF FF FF 00 00 …; rows 2–3 all 00.
3. pattern_sel=1 → each row emits FF FF FF E0 07 FF 07 E0 F8 1F F8 00 00 1F 00 00. Toggling pattern_sel mid-frame has no effect until the next frame.
4. en dropped at mid-ACTIVE → current frame completes with all 4 lines; frame_done pulses; no further cam_vsync appears.
5. rst asserted during ACTIVE line 2 → next clock cam_href=0, cam_data=0, obj_x=obj_y=0; after release with en=1, the full frame restarts from VSYNC.
6. Capture-path loopback (all bytes paired into 16-bit words) → exactly H_PIXEL*V_PIXEL = 32 words per frame; word values match the byte sequences given in scenarios 2 and 3.
